// File: rtl/opera_bus_arbiter.sv
// Two-master Wishbone arbiter (DMA priority, CPU anti-starvation) with chip-select decode; OPERA_BUS_TIMEOUT_EN adds a missing-ack watchdog.
// Grant one cycle after cyc seen in IDLE, ack/data routed combinationally; owner stalls until ack, one IDLE cycle between tenures.
module opera_bus_arbiter #(
    parameter int          DMA_MAX_RUN = 4,
    parameter int          TIMEOUT     = 255,
    parameter logic [31:0] ERR_DATA    = 32'hBAD0_BAD0
) (
    input  logic        sys_clk,
    input  logic        reset_n,
    input  logic        cpu_cyc,
    input  logic        cpu_stb,
    input  logic        cpu_we,
    input  logic [31:0] cpu_adr,
    input  logic [31:0] cpu_dat_w,
    input  logic [3:0]  cpu_sel,
    output logic [31:0] cpu_dat_r,
    output logic        cpu_ack,
    input  logic        dma_cyc,
    input  logic        dma_stb,
    input  logic        dma_we,
    input  logic [31:0] dma_adr,
    input  logic [31:0] dma_dat_w,
    input  logic [3:0]  dma_sel,
    output logic [31:0] dma_dat_r,
    output logic        dma_ack,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_ack,
    output logic        madam_cs,
    output logic        clio_cs,
    output logic        xbus_cs,
    output logic        grant_cpu,
    output logic        grant_dma,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN_CPU = 2'd1,
        OWN_DMA = 2'd2
    } state_t;

    localparam logic [3:0] RUN_MAX = 4'(DMA_MAX_RUN);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_run;
    logic        w_to_fire;
    logic        w_ack_any;
    logic [31:0] w_rdat;

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (cpu_cyc && r_run == RUN_MAX) w_next = OWN_CPU;
                else if (dma_cyc)                w_next = OWN_DMA;
                else if (cpu_cyc)                w_next = OWN_CPU;
            end
            OWN_CPU: if (!cpu_cyc) w_next = IDLE;
            OWN_DMA: if (!dma_cyc) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Counts DMA tenures that finished while the CPU was kept waiting.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_run <= 4'd0;
        end else if (w_next == OWN_CPU && r_state != OWN_CPU) begin
            r_run <= 4'd0;
        end else if (r_state == OWN_DMA && !dma_cyc && cpu_cyc && r_run != RUN_MAX) begin
            r_run <= r_run + 4'd1;
        end
    end

    assign grant_cpu = (r_state == OWN_CPU);
    assign grant_dma = (r_state == OWN_DMA);

    always_comb begin
        o_wb_cyc = 1'b0;
        o_wb_stb = 1'b0;
        o_wb_we  = 1'b0;
        o_wb_adr = 32'd0;
        o_wb_dat = 32'd0;
        o_wb_sel = 4'd0;
        if (grant_cpu) begin
            o_wb_cyc = cpu_cyc;
            o_wb_stb = cpu_stb;
            o_wb_we  = cpu_we;
            o_wb_adr = cpu_adr;
            o_wb_dat = cpu_dat_w;
            o_wb_sel = cpu_sel;
        end else if (grant_dma) begin
            o_wb_cyc = dma_cyc;
            o_wb_stb = dma_stb;
            o_wb_we  = dma_we;
            o_wb_adr = dma_adr;
            o_wb_dat = dma_dat_w;
            o_wb_sel = dma_sel;
        end
    end

    assign madam_cs = o_wb_cyc && (o_wb_adr[31:16] == 16'h0330);
    assign clio_cs  = o_wb_cyc && (o_wb_adr[31:16] == 16'h0340);
    assign xbus_cs  = o_wb_cyc && ((o_wb_adr == 32'h0340_0414) || (o_wb_adr[31:8] == 24'h03_4005));

`ifdef OPERA_BUS_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [7:0] r_to_cnt;
    logic       w_stall;

    assign w_stall   = o_wb_stb && !i_wb_ack;
    // A real ack in the firing cycle suppresses the synthetic one via w_stall.
    assign w_to_fire = w_stall && (r_to_cnt == TO_LAST);

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_to_cnt <= 8'd0;
        end else if (!w_stall || w_to_fire || w_next != r_state) begin
            r_to_cnt <= 8'd0;
        end else begin
            r_to_cnt <= r_to_cnt + 8'd1;
        end
    end
`else
    // Watchdog compiled out: nothing ever fires, a silent slave stalls the owner.
    assign w_to_fire = 1'b0 & (TIMEOUT != 0);
`endif

    assign bus_err   = w_to_fire;
    assign w_ack_any = i_wb_ack || w_to_fire;
    assign w_rdat    = w_to_fire ? ERR_DATA : i_wb_dat;

    assign cpu_ack   = grant_cpu && w_ack_any;
    assign dma_ack   = grant_dma && w_ack_any;
    assign cpu_dat_r = grant_cpu ? w_rdat : 32'd0;
    assign dma_dat_r = grant_dma ? w_rdat : 32'd0;

endmodule

// File: tb/tb_opera_bus_arbiter.sv
// Directed bench for opera_bus_arbiter: small slave model, per-master read-data scoreboards, tenure timing checks.
module tb_opera_bus_arbiter;

    typedef struct {
        logic        madam;
        logic        clio;
        logic        xbus;
        logic        berr;
        logic        oack;
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic [3:0]  sel;
    } snap_t;

    logic        sys_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_cyc = 0, cpu_stb = 0, cpu_we = 0;
    logic [31:0] cpu_adr = 0, cpu_dat_w = 0;
    logic [3:0]  cpu_sel = 0;
    logic [31:0] cpu_dat_r;
    logic        cpu_ack;
    logic        dma_cyc = 0, dma_stb = 0, dma_we = 0;
    logic [31:0] dma_adr = 0, dma_dat_w = 0;
    logic [3:0]  dma_sel = 0;
    logic [31:0] dma_dat_r;
    logic        dma_ack;
    logic        o_wb_cyc, o_wb_stb, o_wb_we;
    logic [31:0] o_wb_adr, o_wb_dat;
    logic [3:0]  o_wb_sel;
    logic [31:0] i_wb_dat = 0;
    logic        i_wb_ack;
    logic        madam_cs, clio_cs, xbus_cs, grant_cpu, grant_dma, bus_err;

    logic slv_ack = 0, stray_ack = 0, slv_en = 1;
    int   slv_lat = 0, slv_cnt = 0;
    int   cyc_n = 0;
    int   checks = 0, failures = 0;

    logic [31:0] q_cpu[$];
    logic [31:0] q_dma[$];

    assign i_wb_ack = slv_ack | stray_ack;

    opera_bus_arbiter #(.DMA_MAX_RUN(4), .TIMEOUT(8), .ERR_DATA(32'hBAD0_BAD0)) dut (
        .sys_clk(sys_clk), .reset_n(reset_n),
        .cpu_cyc(cpu_cyc), .cpu_stb(cpu_stb), .cpu_we(cpu_we), .cpu_adr(cpu_adr),
        .cpu_dat_w(cpu_dat_w), .cpu_sel(cpu_sel), .cpu_dat_r(cpu_dat_r), .cpu_ack(cpu_ack),
        .dma_cyc(dma_cyc), .dma_stb(dma_stb), .dma_we(dma_we), .dma_adr(dma_adr),
        .dma_dat_w(dma_dat_w), .dma_sel(dma_sel), .dma_dat_r(dma_dat_r), .dma_ack(dma_ack),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_adr(o_wb_adr),
        .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel), .i_wb_dat(i_wb_dat), .i_wb_ack(i_wb_ack),
        .madam_cs(madam_cs), .clio_cs(clio_cs), .xbus_cs(xbus_cs),
        .grant_cpu(grant_cpu), .grant_dma(grant_dma), .bus_err(bus_err)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc_n++;

    function automatic logic [31:0] slv_data(input logic [31:0] adr);
        if (adr == 32'h0330_0004) return 32'h1234_5678;
        return {adr[15:0], ~adr[15:0]};
    endfunction

    // Slave: acks slv_lat cycles after first seeing stb, one-cycle ack pulses.
    always @(posedge sys_clk) begin
        #1;
        if (o_wb_cyc && o_wb_stb && slv_en && !slv_ack) begin
            if (slv_cnt >= slv_lat) begin
                slv_ack  = 1'b1;
                i_wb_dat = slv_data(o_wb_adr);
                slv_cnt  = 0;
            end else begin
                slv_cnt++;
            end
        end else begin
            slv_ack  = 1'b0;
            i_wb_dat = 32'd0;
            slv_cnt  = 0;
        end
    end

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [159:0] all_outs();
        return {17'd0, cpu_dat_r, cpu_ack, dma_dat_r, dma_ack, o_wb_cyc, o_wb_stb, o_wb_we,
                o_wb_adr, o_wb_dat, o_wb_sel, madam_cs, clio_cs, xbus_cs, grant_cpu, grant_dma, bus_err};
    endfunction

    task automatic xfer(input bit m, input bit we, input logic [31:0] adr, input logic [31:0] wdat,
                        input logic [3:0] sel, input logic [31:0] exp, input int budget,
                        output int t_r, output int t_g, output int t_a, output bit got, output snap_t sn);
        logic [31:0] e;
        @(negedge sys_clk);
        if (m) begin
            dma_cyc = 1; dma_stb = 1; dma_we = we; dma_adr = adr; dma_dat_w = wdat; dma_sel = sel;
            if (!we) q_dma.push_back(exp);
        end else begin
            cpu_cyc = 1; cpu_stb = 1; cpu_we = we; cpu_adr = adr; cpu_dat_w = wdat; cpu_sel = sel;
            if (!we) q_cpu.push_back(exp);
        end
        t_r = cyc_n; t_g = -1; t_a = -1; got = 0;
        sn = '{madam: 0, clio: 0, xbus: 0, berr: 0, oack: 0, we: 0, adr: 0, wdat: 0, sel: 0};
        for (int i = 0; i < budget; i++) begin
            @(negedge sys_clk);
            if (t_g < 0 && (m ? grant_dma : grant_cpu)) t_g = cyc_n;
            if (m ? dma_ack : cpu_ack) begin
                got = 1;
                t_a = cyc_n;
                sn = '{madam: madam_cs, clio: clio_cs, xbus: xbus_cs, berr: bus_err,
                       oack: (m ? cpu_ack : dma_ack), we: o_wb_we, adr: o_wb_adr,
                       wdat: o_wb_dat, sel: o_wb_sel};
                if (!we) begin
                    e = m ? q_dma.pop_front() : q_cpu.pop_front();
                    check(m ? "dma_rdata" : "cpu_rdata", m ? dma_dat_r : cpu_dat_r, e);
                end
                break;
            end
        end
        if (!got && !we) begin
            if (m) void'(q_dma.pop_front());
            else   void'(q_cpu.pop_front());
        end
        if (m) begin
            dma_cyc = 0; dma_stb = 0; dma_we = 0; dma_adr = 0; dma_dat_w = 0; dma_sel = 0;
        end else begin
            cpu_cyc = 0; cpu_stb = 0; cpu_we = 0; cpu_adr = 0; cpu_dat_w = 0; cpu_sel = 0;
        end
    endtask

    int    c_tr, c_tg, c_ta, d_tr, d_tg, d_ta, c2_tr, c2_tg, c2_ta;
    int    dtr[6], dtg[6], dta[6];
    bit    c_got, d_got, c2_got;
    bit    dgot[6];
    snap_t sn_c, sn_d, sn_c2;
    snap_t sn_dv[6];

    initial begin
        #3;
        check("reset_outputs", all_outs(), 160'd0);
        @(negedge sys_clk);
        reset_n = 1;
        @(negedge sys_clk);
        check("idle_outputs", all_outs(), 160'd0);

        // Stray ack with no owner must not reach either master.
        stray_ack = 1;
        #1;
        check("stray_ack", {cpu_ack, dma_ack, cpu_dat_r, dma_dat_r}, 160'd0);
        stray_ack = 0;

        // CPU-only read into the MADAM window.
        slv_lat = 2;
        xfer(0, 0, 32'h0330_0004, 0, 4'hF, 32'h1234_5678, 50, c_tr, c_tg, c_ta, c_got, sn_c);
        check("t1_got_ack", c_got, 1);
        check("t1_grant_latency", c_tg, c_tr + 1);
        check("t1_ack_latency", c_ta, c_tg + 2);
        check("t1_madam_cs", {sn_c.madam, sn_c.clio, sn_c.xbus}, 3'b100);
        check("t1_dma_ack_low", sn_c.oack, 0);

        // Simultaneous requests: DMA first, one IDLE cycle, then CPU.
        slv_lat = 1;
        fork
            xfer(1, 0, 32'h0000_1000, 0, 4'hF, 32'h1000_EFFF, 50, d_tr, d_tg, d_ta, d_got, sn_d);
            xfer(0, 0, 32'h0000_2000, 0, 4'hF, 32'h2000_DFFF, 50, c_tr, c_tg, c_ta, c_got, sn_c);
        join
        check("t2_both_acked", {d_got, c_got}, 2'b11);
        check("t2_dma_first", d_tg, d_tr + 1);
        check("t2_cpu_after_idle", c_tg, d_ta + 2);

        // Six DMA tenures with CPU waiting: CPU cuts in after the fourth.
        slv_lat = 0;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    xfer(1, 1, 32'h0010_0000 + i * 4, 32'h0D0D_0000 + i, 4'hF, 0, 100,
                         dtr[i], dtg[i], dta[i], dgot[i], sn_dv[i]);
            end
            begin
                xfer(0, 1, 32'h0020_0000, 32'h0C0C_0001, 4'hF, 0, 100, c_tr, c_tg, c_ta, c_got, sn_c);
                xfer(0, 1, 32'h0020_0004, 32'h0C0C_0002, 4'hF, 0, 100, c2_tr, c2_tg, c2_ta, c2_got, sn_c2);
            end
        join
        check("t3_all_acked", {dgot[0], dgot[1], dgot[2], dgot[3], dgot[4], dgot[5], c_got, c2_got}, 8'hFF);
        check("t3_dma_back_to_back", dtg[1], dta[0] + 2);
        check("t3_cpu_after_4th", c_tg, dta[3] + 2);
        check("t3_dma_resumes", dtg[4], c_ta + 2);
        check("t3_run_cleared", c2_tg, dta[5] + 2);

        // XBUS/CLIO decode and write pass-through.
        slv_lat = 1;
        xfer(0, 1, 32'h0340_0414, 32'hCAFE_F00D, 4'b0110, 0, 50, c_tr, c_tg, c_ta, c_got, sn_c);
        check("t4_wr_got_ack", c_got, 1);
        check("t4_wr_cs", {sn_c.madam, sn_c.clio, sn_c.xbus}, 3'b011);
        check("t4_wr_passthru", {sn_c.we, sn_c.adr, sn_c.wdat, sn_c.sel},
              {1'b1, 32'h0340_0414, 32'hCAFE_F00D, 4'b0110});
        xfer(0, 0, 32'h0340_0100, 0, 4'hF, 32'h0100_FEFF, 50, c_tr, c_tg, c_ta, c_got, sn_c);
        check("t4_rd_cs", {c_got, sn_c.madam, sn_c.clio, sn_c.xbus}, 4'b1010);
        xfer(1, 0, 32'h0340_0550, 0, 4'hF, 32'h0550_FAAF, 50, d_tr, d_tg, d_ta, d_got, sn_d);
        check("t4_xbus_range_cs", {d_got, sn_d.clio, sn_d.xbus}, 3'b111);

        // Silent slave.
        slv_en = 0;
`ifdef OPERA_BUS_TIMEOUT_EN
        xfer(0, 0, 32'h0330_0100, 0, 4'hF, 32'hBAD0_BAD0, 50, c_tr, c_tg, c_ta, c_got, sn_c);
        check("t5_timeout_ack", c_got, 1);
        check("t5_timeout_cycle", c_ta, c_tg + 7);
        check("t5_bus_err", sn_c.berr, 1);
`else
        xfer(0, 0, 32'h0330_0100, 0, 4'hF, 32'hBAD0_BAD0, 300, c_tr, c_tg, c_ta, c_got, sn_c);
        check("t5_no_ack", c_got, 0);
        check("t5_no_bus_err", bus_err, 0);
`endif

        // Reset in the middle of a DMA tenure.
        @(negedge sys_clk);
        dma_cyc = 1; dma_stb = 1; dma_adr = 32'h0330_0010; dma_sel = 4'hF;
        repeat (3) @(negedge sys_clk);
        check("t6_dma_owns", {grant_dma, o_wb_cyc, madam_cs}, 3'b111);
        #2 reset_n = 0;
        #1;
        check("t6_async_reset_outputs", all_outs(), 160'd0);
        @(negedge sys_clk);
        reset_n = 1;
        check("t6_held_in_idle", grant_dma, 0);
        @(negedge sys_clk);
        check("t6_regrant", {grant_dma, grant_cpu, o_wb_cyc}, 3'b101);
        dma_cyc = 0; dma_stb = 0; dma_adr = 0; dma_sel = 0;
        slv_en = 1;
        repeat (2) @(negedge sys_clk);
        check("final_idle", all_outs(), 160'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
